// File: rtl/gf2m_inv.sv
// Fermat inverter over GF(2^WIDTH): op_c = op_a^(2^WIDTH-2), sequencing one external gf2m_mul.
// Optional `ZERO_CHK_EN: a zero operand finishes at once with op_c=0 and zero_err=1.
module gf2m_inv #(
    parameter int WIDTH = 79,
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] op_c,
    output logic             zero_err,
    output logic             mul_start,
    output logic [WIDTH-1:0] mul_op_a,
    output logic [WIDTH-1:0] mul_op_b,
    input  logic             mul_done,
    input  logic [WIDTH-1:0] mul_op_c
);

    typedef enum logic [2:0] {
        IDLE, SQ_ISS, SQ_WT, MA_ISS, MA_WT, FS_ISS, FS_WT, FIN
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   r;
    logic [CNT_W-1:0]   cnt;

`ifndef ZERO_CHK_EN
    assign zero_err = 1'b0;
`endif

    // Operands for the next product are loaded on the edge that enters *_ISS,
    // so they are already stable in the mul_start cycle.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            mul_start <= 1'b0;
            op_c      <= '0;
            mul_op_a  <= '0;
            mul_op_b  <= '0;
            a         <= '0;
            r         <= '0;
            cnt       <= '0;
`ifdef ZERO_CHK_EN
            zero_err  <= 1'b0;
`endif
        end else begin
            done      <= 1'b0;
            mul_start <= 1'b0;
            case (state)
                IDLE: begin
                    // The done cycle is still idle but must not accept a new start.
                    if (start && !done) begin
                        a    <= op_a;
                        r    <= op_a;
                        cnt  <= '0;
                        busy <= 1'b1;
`ifdef ZERO_CHK_EN
                        zero_err <= (op_a == '0);
                        if (op_a == '0) begin
                            state <= FIN;
                        end else begin
                            mul_start <= 1'b1;
                            mul_op_a  <= op_a;
                            mul_op_b  <= op_a;
                            state     <= SQ_ISS;
                        end
`else
                        mul_start <= 1'b1;
                        mul_op_a  <= op_a;
                        mul_op_b  <= op_a;
                        state     <= SQ_ISS;
`endif
                    end
                end
                SQ_ISS: state <= SQ_WT;
                SQ_WT: begin
                    if (mul_done) begin
                        r         <= mul_op_c;
                        mul_op_a  <= mul_op_c;
                        mul_op_b  <= a;
                        mul_start <= 1'b1;
                        state     <= MA_ISS;
                    end
                end
                MA_ISS: state <= MA_WT;
                MA_WT: begin
                    if (mul_done) begin
                        r         <= mul_op_c;
                        mul_op_a  <= mul_op_c;
                        mul_op_b  <= mul_op_c;
                        mul_start <= 1'b1;
                        if (cnt == CNT_W'(WIDTH - 3)) begin
                            state <= FS_ISS;
                        end else begin
                            cnt   <= cnt + CNT_W'(1);
                            state <= SQ_ISS;
                        end
                    end
                end
                FS_ISS: state <= FS_WT;
                FS_WT: begin
                    if (mul_done) begin
                        r     <= mul_op_c;
                        state <= FIN;
                    end
                end
                FIN: begin
                    op_c  <= r;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gf2m_inv.sv
// Bench for gf2m_inv: behavioural GF(2^79) multiplier responder (poly x^79+x^9+1,
// bit WIDTH-1 = x^0) plus a cycle-level reference model checked every cycle.
module tb_gf2m_inv;
    localparam int W    = 79;
    localparam int NMUL = 2 * W - 3;
    localparam logic [W-1:0] ONE = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] X1  = {2'b01, {(W-2){1'b0}}};

`ifdef ZERO_CHK_EN
    localparam bit ZCHK = 1'b1;
`else
    localparam bit ZCHK = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_b = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] op_a = '0;
    logic         busy, done, zero_err, mul_start;
    logic [W-1:0] op_c, mul_op_a, mul_op_b;
    logic         mul_done = 1'b0;
    logic [W-1:0] mul_op_c = '0;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    gf2m_inv #(.WIDTH(W), .CNT_W(7)) dut (
        .clk(clk), .rst_b(rst_b), .start(start), .op_a(op_a),
        .busy(busy), .done(done), .op_c(op_c), .zero_err(zero_err),
        .mul_start(mul_start), .mul_op_a(mul_op_a), .mul_op_b(mul_op_b),
        .mul_done(mul_done), .mul_op_c(mul_op_c)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // ---------------- field arithmetic ----------------
    function automatic logic [W-1:0] rev(input logic [W-1:0] v);
        logic [W-1:0] o;
        for (int i = 0; i < W; i++) o[i] = v[W-1-i];
        return o;
    endfunction

    function automatic logic [W-1:0] nmul(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [2*W-2:0] p;
        p = '0;
        for (int i = 0; i < W; i++)
            if (y[i]) p = p ^ ({{(W-1){1'b0}}, x} << i);
        for (int i = 2*W-2; i >= W; i--)
            if (p[i]) begin
                p[i]       = 1'b0;
                p[i-W]     = ~p[i-W];
                p[i-W+9]   = ~p[i-W+9];
            end
        return p[W-1:0];
    endfunction

    function automatic logic [W-1:0] gmul(input logic [W-1:0] x, input logic [W-1:0] y);
        return rev(nmul(rev(x), rev(y)));
    endfunction

    // a^-1 = a^(2+4+...+2^(W-1)) = product of a^(2^i), i=1..W-1
    function automatic logic [W-1:0] inv(input logic [W-1:0] x);
        logic [W-1:0] s, p;
        s = x;
        p = ONE;
        for (int i = 1; i < W; i++) begin
            s = gmul(s, s);
            p = gmul(p, s);
        end
        return p;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got=%h expected=%h", name, cyc, got, exp);
        end
    endtask

    // ---------------- multiplier responder ----------------
    int           lat_l = 1;
    int           pend = 0;
    int           n_mstart = 0;
    int           t_ms = 0, t_md = 0;
    logic         stray = 1'b0;
    logic [W-1:0] la, lb, prod;

    always @(negedge clk) begin
        mul_done = 1'b0;
        if (!rst_b) begin
            pend = 0;
        end else begin
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    chk("mul_op_a_stable", mul_op_a, la);
                    chk("mul_op_b_stable", mul_op_b, lb);
                    mul_done = 1'b1;
                    mul_op_c = prod;
                    t_md     = cyc;
                end
            end
            if (stray) begin
                mul_done = 1'b1;
                mul_op_c = {W{1'b1}};
            end
            if (mul_start) begin
                n_mstart++;
                la   = mul_op_a;
                lb   = mul_op_b;
                prod = gmul(la, lb);
                pend = lat_l;
                t_ms = cyc;
            end
        end
    end

    // ---------------- reference model + per-cycle compare ----------------
    bit           armed = 1'b0;
    bit           m_act = 1'b0;
    int           m_done_at = 0, m_nmul = 0, n_at_acc = 0;
    logic [W-1:0] m_exp = '0, m_res = '0;
    logic         m_zerr = 1'b0;

    always @(negedge clk) begin
        logic exp_done;
        exp_done = 1'b0;
        if (armed) begin
            exp_done = m_act && (cyc == m_done_at);
            if (exp_done) begin
                m_res = m_exp;
                m_act = 1'b0;
                chk("mul_start_count", W'(n_mstart - n_at_acc), W'(m_nmul));
            end
            chk("done", W'(done), W'(exp_done));
            chk("busy", W'(busy), W'(m_act));
            chk("op_c", op_c, m_res);
            chk("zero_err", W'(zero_err), W'(m_zerr));
        end
        if (!rst_b) begin
            armed  = 1'b1;
            m_act  = 1'b0;
            m_res  = '0;
            m_zerr = 1'b0;
        end else if (armed && start && !m_act && !exp_done) begin
            m_act     = 1'b1;
            m_exp     = inv(op_a);
            m_zerr    = ZCHK && (op_a == '0);
            m_nmul    = m_zerr ? 0 : NMUL;
            m_done_at = cyc + (m_zerr ? 2 : 2 + NMUL * (lat_l + 1));
            n_at_acc  = n_mstart;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [W-1:0] v);
        op_a  = v;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) begin
            errors++;
            checks++;
            $display("FAIL done_timeout at cycle %0d: got=no done expected=done", cyc);
        end
    endtask

    task automatic run(input logic [W-1:0] v, output logic [W-1:0] res);
        bit ok;
        go(v);
        wait_done(ok);
        res = op_c;
    endtask

    initial begin
        logic [W-1:0] res, res2, xv, b;
        int           cs, n0;
        bit           ok;

        repeat (3) tick();
        rst_b = 1'b1;
        chk("reset_busy", W'(busy), '0);
        chk("reset_done", W'(done), '0);
        chk("reset_op_c", op_c, '0);
        chk("reset_mul_start", W'(mul_start), '0);
        chk("reset_mul_op_a", mul_op_a, '0);
        chk("reset_zero_err", W'(zero_err), '0);

        // model pins against hand-derived values (x * x^78 = x^9 + 1, x^-1 = x^78 + x^8)
        chk("pin_mul_x_x78", gmul(X1, W'(1)), ONE | (W'(1) << 69));
        chk("pin_inv_one", inv(ONE), ONE);
        chk("pin_inv_x", inv(X1), W'(1) | (W'(1) << 70));

        // 1: ONE, multiplier latency 3, count and latency formula
        lat_l = 3;
        tick();
        n0 = n_mstart;
        cs = cyc;
        go(ONE);
        wait_done(ok);
        chk("one_result", op_c, ONE);
        chk("one_mul_starts", W'(n_mstart - n0), W'(NMUL));
        chk("one_latency", W'(cyc - cs), W'(2 + NMUL * (t_md - t_ms + 1)));

        // directed: inverse of x
        lat_l = 1;
        tick();
        run(X1, res);
        chk("inv_x_result", res, W'(1) | (W'(1) << 70));

        // 2: random nonzero operands
        for (int k = 0; k < 30; k++) begin
            lat_l = $urandom_range(1, 2);
            b = {$urandom, $urandom, $urandom};
            if (b == '0) b = ONE;
            tick();
            run(b, res);
            chk("rand_a_times_inv", gmul(b, res), ONE);
        end

        // 3: involution
        lat_l = 1;
        xv = {$urandom, $urandom, $urandom} | W'(1);
        tick();
        run(xv, res);
        tick();
        run(res, res2);
        chk("involution", res2, xv);

        // 4: zero operand
        tick();
        n0 = n_mstart;
        cs = cyc;
        go('0);
        wait_done(ok);
        chk("zero_result", op_c, '0);
        chk("zero_err_flag", W'(zero_err), W'(ZCHK));
        chk("zero_mul_starts", W'(n_mstart - n0), ZCHK ? '0 : W'(NMUL));
        chk("zero_latency", W'(cyc - cs), ZCHK ? W'(2) : W'(2 + NMUL * 2));

        // 5: starts while busy and in the done cycle are ignored
        xv = {$urandom, $urandom, $urandom} | ONE;
        tick();
        go(xv);
        repeat (46) tick();
        op_a  = ONE;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(ok);
        op_a  = X1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        chk("ignored_start_busy", W'(busy), '0);
        chk("ignored_start_op_c", op_c, inv(xv));

        // stray mul_done together with start in IDLE
        xv = {$urandom, $urandom, $urandom} | W'(2);
        op_a  = xv;
        start = 1'b1;
        stray = 1'b1;
        tick();
        start = 1'b0;
        stray = 1'b0;
        wait_done(ok);
        chk("stray_done_result", op_c, inv(xv));

        // 6: reset mid-run
        lat_l = 3;
        tick();
        go(xv);
        repeat (398) tick();
        rst_b = 1'b0;
        tick();
        rst_b = 1'b1;
        chk("midrst_busy", W'(busy), '0);
        chk("midrst_done", W'(done), '0);
        chk("midrst_op_c", op_c, '0);
        chk("midrst_mul_start", W'(mul_start), '0);
        chk("midrst_mul_op_a", mul_op_a, '0);
        chk("midrst_mul_op_b", mul_op_b, '0);
        lat_l = 1;
        tick();
        run(X1, res);
        chk("after_rst_result", res, W'(1) | (W'(1) << 70));

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
